demux_1to2_stream: RTL and testbench
====================================

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8: the payload width in bits.
REQ-003 clk  input  1  Rising-edge clock.
REQ-004 rst_n  input  1  Asynchronous active-low reset.
REQ-005 s_valid  input  1  Upstream beat valid.
REQ-006 s_ready  output  1  Block can accept the upstream beat this cycle.
REQ-007 s_data  input  DATA_W  Upstream payload.
REQ-008 s_last  input  1  Marks the final beat of a packet.
REQ-009 sel  input  1  Destination select (0 = port 0, 1 = port 1); sampled only on the first beat of a packet.
REQ-010 m0_valid, m1_valid  output  1 each  Output port beat valid.
REQ-011 m0_ready, m1_ready  input  1 each  Downstream accepts the beat.
REQ-012 m0_data, m1_data  output  DATA_W each  Output payload (registered).
REQ-013 m0_last, m1_last  output  1 each  Output last flag (registered).
REQ-014 pkt_cnt0, pkt_cnt1  output  8 each  Number of packets completed per port; wraps modulo 256.

Function
REQ-015 Handshake: a transfer occurs on a port when its valid and ready are both high at the rising clk edge.
REQ-016 Each output port SHALL have one register slot holding data, last and valid.
REQ-017 State machine states:
- IDLE: no packet in progress.
- LOCK0: packet in progress, routed to port 0.
- LOCK1: packet in progress, routed to port 1.
REQ-018 Target port: sel when in IDLE; the locked port in LOCK0 or LOCK1.
REQ-019 s_ready SHALL be combinational. It is high when the target slot is empty, or when the target slot is full and being drained this cycle (mX_valid and mX_ready both high).
REQ-020 An accepted beat SHALL load the target slot in the same edge. mX_valid rises one cycle after acceptance, so latency is 1 cycle.
REQ-021 Sustained throughput SHALL be 1 beat per cycle when the target port's ready stays high.
REQ-022 Transitions:
- IDLE to LOCKsel on an accepted beat with s_last=0.
- IDLE stays in IDLE on an accepted beat with s_last=1 (single-beat packet).
- LOCKx to IDLE on an accepted beat with s_last=1.
- All other cases hold the current state.
REQ-023 sel changes while in LOCK0 or LOCK1 SHALL be ignored.
REQ-024 A slot drained with no new load in the same cycle SHALL clear mX_valid.
REQ-025 A simultaneous drain and load SHALL keep mX_valid high and replace the data with the new beat.
REQ-026 mX_data and mX_last SHALL hold stable while mX_valid=1 and mX_ready=0.
REQ-027 Backpressure on the non-target port SHALL NOT affect s_ready. The other slot SHALL continue to drain independently.
REQ-028 Head-of-line blocking is intended. In IDLE, if sel points to a full, undrained slot, s_ready=0 even if the other port is free.
REQ-029 pkt_cntX SHALL increment by 1 when port X transfers a beat with mX_last=1. It wraps from 255 to 0.
REQ-030 With s_valid=0, no state, slot or counter SHALL change except draining.

Reset
REQ-031 While rst_n=0, asynchronously:
- State is IDLE.
- m0_valid and m1_valid are 0.
- m0_data, m1_data, m0_last and m1_last are 0.
- pkt_cnt0 and pkt_cnt1 are 0.
REQ-032 While rst_n=0, s_ready SHALL be 0.
REQ-033 Reset during a packet SHALL discard the partial packet and any held slot contents.
REQ-034 The first beat after reset release SHALL be treated as a packet start (sel is sampled).

Verification
REQ-035 Single-beat routing: sel=1, s_data=8'hA5, s_last=1, both readies high.
- Next cycle: m1_valid=1, m1_data=A5, m1_last=1, m0_valid=0.
- pkt_cnt1 becomes 1 after the drain.
REQ-036 Packet lock: 4-beat packet 01,02,03,04 with sel=0 on beat 1, then sel=1 for beats 2-4.
- All four beats appear on port 0 in order, back-to-back.
- m1_valid stays 0.
- pkt_cnt0=1.
REQ-037 Backpressure: m0_ready=0 after one beat has loaded into the port 0 slot.
- s_ready=0 for port-0 traffic.
- m0_data stays stable for 5 cycles.
- Raising m0_ready drains the held beat and accepts the next beat on the same edge.
REQ-038 Independent ports:
- Port 0 is stalled holding a beat.
- A new packet is sent with sel=1; it is accepted and delivered on port 1.
- Port 0 contents are unchanged.
REQ-039 Reset mid-packet: rst_n=0 asserted after beat 2 of a 4-beat packet to port 1.
- Immediately: all valids are 0 and both counters are 0.
- After release, a beat with sel=0 routes to port 0.
REQ-040 Counter wrap: send 256 single-beat packets to port 0.
- pkt_cnt0 reads 255 after the 255th drain and 0 after the 256th.

Source files
------------

// File: rtl/demux_1to2_stream.sv
// 1-to-2 packet stream demultiplexer. The destination is chosen from sel on a packet's
// first beat and held until its last beat. Each output has a single registered slot.
module demux_1to2_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [7:0]        pkt_cnt0,
  output logic [7:0]        pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_m0_valid;
  logic                r_m0_last;
  logic [DATA_W-1:0]   r_m0_data;
  logic                r_m1_valid;
  logic                r_m1_last;
  logic [DATA_W-1:0]   r_m1_data;
  logic [7:0]          r_cnt0;
  logic [7:0]          r_cnt1;

  logic                w_tgt;
  logic                w_drain0;
  logic                w_drain1;
  logic                w_free0;
  logic                w_free1;
  logic                w_ready;
  logic                w_acc;
  logic                w_load0;
  logic                w_load1;

  // A slot counts as free when it is empty or is being drained on this same edge.
  always_comb begin
    w_tgt    = (r_state == IDLE) ? sel : (r_state == LOCK1);
    w_drain0 = r_m0_valid & m0_ready;
    w_drain1 = r_m1_valid & m1_ready;
    w_free0  = ~r_m0_valid | w_drain0;
    w_free1  = ~r_m1_valid | w_drain1;
    w_ready  = rst_n & (w_tgt ? w_free1 : w_free0);
    w_acc    = s_valid & w_ready;
    w_load0  = w_acc & ~w_tgt;
    w_load1  = w_acc & w_tgt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_acc && !s_last) w_state_nxt = sel ? LOCK1 : LOCK0;
      LOCK0,
      LOCK1:   if (w_acc && s_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_valid <= 1'b0;
      r_m0_last  <= 1'b0;
      r_m0_data  <= '0;
    end else if (w_load0) begin
      r_m0_valid <= 1'b1;
      r_m0_last  <= s_last;
      r_m0_data  <= s_data;
    end else if (w_drain0) begin
      r_m0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1_valid <= 1'b0;
      r_m1_last  <= 1'b0;
      r_m1_data  <= '0;
    end else if (w_load1) begin
      r_m1_valid <= 1'b1;
      r_m1_last  <= s_last;
      r_m1_data  <= s_data;
    end else if (w_drain1) begin
      r_m1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0 && r_m0_last) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_drain1 && r_m1_last) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign s_ready  = w_ready;
  assign m0_valid = r_m0_valid;
  assign m0_data  = r_m0_data;
  assign m0_last  = r_m0_last;
  assign m1_valid = r_m1_valid;
  assign m1_data  = r_m1_data;
  assign m1_last  = r_m1_last;
  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream. A negedge monitor keeps per-port expected queues
// and packet counts; the initial block walks through routing, lock, backpressure, reset and wrap.
module tb_demux_1to2_stream;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       sel;
  logic       m0_valid;
  logic       m0_ready;
  logic [7:0] m0_data;
  logic       m0_last;
  logic       m1_valid;
  logic       m1_ready;
  logic [7:0] m1_data;
  logic       m1_last;
  logic [7:0] pkt_cnt0;
  logic [7:0] pkt_cnt1;

  int total = 0;
  int bad   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] ec0, ec1;
  int         lk;
  logic       hold0, hold1;
  logic [8:0] hv0, hv1;

  demux_1to2_stream #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .sel(sel),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_last(m0_last),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_last(m1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes are evaluated at negedge, where inputs are stable until the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      ec0 = '0; ec1 = '0; lk = 0;
      hold0 = 1'b0; hold1 = 1'b0;
    end else begin
      chk("pkt_cnt0_model", {24'd0, pkt_cnt0}, {24'd0, ec0});
      chk("pkt_cnt1_model", {24'd0, pkt_cnt1}, {24'd0, ec1});
      if (hold0) chk("m0_hold_stable", {22'd0, m0_valid, m0_last, m0_data}, {22'd0, 1'b1, hv0});
      if (hold1) chk("m1_hold_stable", {22'd0, m1_valid, m1_last, m1_data}, {22'd0, 1'b1, hv1});
      hold0 = m0_valid && !m0_ready; hv0 = {m0_last, m0_data};
      hold1 = m1_valid && !m1_ready; hv1 = {m1_last, m1_data};
      if (m0_valid && m0_ready) begin
        if (q0.size() == 0) chk("m0_unexpected_beat", {23'd0, m0_last, m0_data}, 32'hFFFF_FFFF);
        else begin
          chk("m0_beat", {23'd0, m0_last, m0_data}, {23'd0, q0.pop_front()});
          if (m0_last) ec0 = ec0 + 8'd1;
        end
      end
      if (m1_valid && m1_ready) begin
        if (q1.size() == 0) chk("m1_unexpected_beat", {23'd0, m1_last, m1_data}, 32'hFFFF_FFFF);
        else begin
          chk("m1_beat", {23'd0, m1_last, m1_data}, {23'd0, q1.pop_front()});
          if (m1_last) ec1 = ec1 + 8'd1;
        end
      end
      if (s_valid && s_ready) begin
        if (((lk == 0) ? sel : (lk == 2)) == 1'b1) q1.push_back({s_last, s_data});
        else                                      q0.push_back({s_last, s_data});
        if (lk == 0 && !s_last)     lk = sel ? 2 : 1;
        else if (lk != 0 && s_last) lk = 0;
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that accepted the beat.
  task automatic send(input logic [7:0] d, input logic l, input logic s, output int n);
    logic acc;
    s_valid = 1'b1; s_data = d; s_last = l; sel = s;
    n = 0;
    do begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    chk("send_accept", {31'd0, acc}, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; sel = 1'b0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b1;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_valids", {30'd0, m0_valid, m1_valid}, 32'd0);
    chk("rst_data_last", {14'd0, m0_last, m1_last, m0_data, m1_data}, 32'd0);
    chk("rst_cnts", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-beat routing to port 1
    send(8'hA5, 1'b1, 1'b1, n);
    chk("single_m1", {22'd0, m1_valid, m1_last, m1_data}, {22'd0, 1'b1, 1'b1, 8'hA5});
    chk("single_m0_idle", {31'd0, m0_valid}, 32'd0);
    @(posedge clk); #1;
    chk("single_cnt1", {24'd0, pkt_cnt1}, 32'd1);

    // Packet lock: sel flips after the first beat but all beats stay on port 0
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), (i == 4), (i != 1), n);
      chk("lock_cycles", n, 32'd1);
      chk("lock_m0", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'(i)});
      chk("lock_m1_idle", {31'd0, m1_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("lock_cnt0", {24'd0, pkt_cnt0}, 32'd1);

    // Backpressure on port 0, head-of-line blocking while port 1 is free
    m0_ready = 1'b0;
    send(8'h10, 1'b1, 1'b0, n);
    s_valid = 1'b1; s_data = 8'h11; s_last = 1'b1; sel = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_m0_data", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'h10});
      @(posedge clk); #1;
    end
    m0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("bp_reload", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'h11});
    @(posedge clk); #1;

    // Independent ports: port 0 stalled, port 1 still flows
    m0_ready = 1'b0;
    send(8'h20, 1'b1, 1'b0, n);
    send(8'h30, 1'b1, 1'b1, n);
    chk("indep_cycles", n, 32'd1);
    chk("indep_m1", {23'd0, m1_valid, m1_data}, {23'd0, 1'b1, 8'h30});
    chk("indep_m0", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'h20});
    @(posedge clk); #1;
    chk("indep_m1_drained", {31'd0, m1_valid}, 32'd0);
    chk("indep_m0_held", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'h20});
    m0_ready = 1'b1;
    @(posedge clk); #1;
    chk("indep_m0_drained", {31'd0, m0_valid}, 32'd0);

    // Reset in the middle of a port-1 packet
    send(8'h40, 1'b0, 1'b1, n);
    send(8'h41, 1'b0, 1'b1, n);
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", {30'd0, m0_valid, m1_valid}, 32'd0);
    chk("midrst_cnts", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
    chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h50, 1'b1, 1'b0, n);
    chk("postrst_m0", {23'd0, m0_valid, m0_data}, {23'd0, 1'b1, 8'h50});
    chk("postrst_m1_idle", {31'd0, m1_valid}, 32'd0);
    @(posedge clk); #1;

    // Counter wrap on port 0
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      send(8'(i), 1'b1, 1'b0, n);
      if (i == 256) chk("wrap_cnt0_255", {24'd0, pkt_cnt0}, 32'd255);
    end
    @(posedge clk); #1;
    chk("wrap_cnt0_0", {24'd0, pkt_cnt0}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
